// File: rtl/csr_queue_pkg.sv
// Shared types for the CSR queue: the riscv and ariane_pkg definitions it relies on,
// plus queue-local helpers.
package riscv;
  localparam int unsigned XLEN = 64;
  typedef logic [XLEN-1:0] xlen_t;
endpackage

package ariane_pkg;
  localparam int unsigned NR_SB_ENTRIES = 8;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
  localparam int unsigned CSR_ADDR_BITS = 12;

  typedef enum logic [3:0] {
    ADD,
    CSR_WRITE,
    CSR_READ,
    CSR_SET,
    CSR_CLEAR
  } fu_op;

  typedef struct packed {
    fu_op                     operation;
    riscv::xlen_t             operand_a;
    riscv::xlen_t             operand_b;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    fu_op                     op;
    riscv::xlen_t             wdata;
    logic [CSR_ADDR_BITS-1:0] addr;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } csr_queue_entry_t;
endpackage

package csr_queue_pkg;
  // A single-entry queue still needs a one-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/csr_queue.sv
// In-order buffer of issued CSR operations; presents the oldest entry to the CSR
// file and releases it on commit. Optional serialise mode limits it to one in flight.
module csr_queue
  import ariane_pkg::*;
  import csr_queue_pkg::*;
#(
  parameter int unsigned DEPTH          = 2,
  parameter bit          SERIALIZE      = 1'b0,
  parameter int unsigned CSR_ADDR_WIDTH = 12
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  fu_data_t                     fu_data_i,
  input  logic                         csr_valid_i,
  output logic                         csr_ready_o,
  output riscv::xlen_t                 csr_result_o,
  input  logic                         csr_commit_i,
  output logic [CSR_ADDR_WIDTH-1:0]    csr_addr_o,
  output fu_op                         csr_op_o,
  output riscv::xlen_t                 csr_wdata_o,
  output logic [TRANS_ID_BITS-1:0]     csr_trans_id_o,
  output logic                         csr_pending_o,
  output logic [$clog2(DEPTH+1)-1:0]   csr_count_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  csr_queue_entry_t       mem_q [DEPTH];
  csr_queue_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   push, pop, empty;
  csr_queue_entry_t       new_entry, head;
  logic                   unused_operand_b;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign unused_operand_b = ^fu_data_i.operand_b[riscv::XLEN-1:CSR_ADDR_WIDTH];

  assign empty       = (count_q == '0);
  assign csr_ready_o = SERIALIZE ? empty : (count_q != CNT_W'(DEPTH));
  assign push        = csr_valid_i && csr_ready_o;
  assign pop         = csr_commit_i && !empty;

  assign csr_result_o  = fu_data_i.operand_a;
  assign csr_pending_o = !empty;
  assign csr_count_o   = count_q;

  // The address field is package-wide; narrower CSR address widths zero-extend into it.
  always_comb begin
    new_entry          = '0;
    new_entry.op       = fu_data_i.operation;
    new_entry.wdata    = fu_data_i.operand_a;
    new_entry.addr     = CSR_ADDR_BITS'(fu_data_i.operand_b[CSR_ADDR_WIDTH-1:0]);
    new_entry.trans_id = fu_data_i.trans_id;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Stale storage is masked so an empty queue shows a harmless ADD with zero fields.
  always_comb begin
    head           = mem_q[rd_ptr_q];
    csr_addr_o     = '0;
    csr_op_o       = ADD;
    csr_wdata_o    = '0;
    csr_trans_id_o = '0;
    if (!empty) begin
      csr_addr_o     = CSR_ADDR_WIDTH'(head.addr);
      csr_op_o       = head.op;
      csr_wdata_o    = head.wdata;
      csr_trans_id_o = head.trans_id;
    end
  end

  commit_on_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(csr_commit_i && empty))
    else $warning("csr_queue: commit with empty queue ignored");

endmodule

// File: tb/tb_csr_queue.sv
// Directed bench for csr_queue: a DEPTH=2 instance for the main queue behaviour and a
// DEPTH=4 serialising instance for serialise mode and asynchronous reset.
module tb_csr_queue;
  import ariane_pkg::*;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fu_data_t fu;

  logic         rst_n, flush, valid, commit, ready, pending;
  riscv::xlen_t result, wdata;
  logic [11:0]  addr;
  fu_op         op;
  logic [2:0]   tid;
  logic [1:0]   count;

  logic         rst_s, flush_s, valid_s, commit_s, ready_s, pending_s;
  riscv::xlen_t result_s, wdata_s;
  logic [11:0]  addr_s;
  fu_op         op_s;
  logic [2:0]   tid_s;
  logic [2:0]   count_s;

  int total;
  int bad;

  csr_queue #(.DEPTH(2), .SERIALIZE(1'b0), .CSR_ADDR_WIDTH(12)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .fu_data_i(fu),
    .csr_valid_i(valid), .csr_ready_o(ready), .csr_result_o(result),
    .csr_commit_i(commit), .csr_addr_o(addr), .csr_op_o(op),
    .csr_wdata_o(wdata), .csr_trans_id_o(tid), .csr_pending_o(pending),
    .csr_count_o(count)
  );

  csr_queue #(.DEPTH(4), .SERIALIZE(1'b1), .CSR_ADDR_WIDTH(12)) u_ser (
    .clk_i(clk), .rst_ni(rst_s), .flush_i(flush_s), .fu_data_i(fu),
    .csr_valid_i(valid_s), .csr_ready_o(ready_s), .csr_result_o(result_s),
    .csr_commit_i(commit_s), .csr_addr_o(addr_s), .csr_op_o(op_s),
    .csr_wdata_o(wdata_s), .csr_trans_id_o(tid_s), .csr_pending_o(pending_s),
    .csr_count_o(count_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input fu_op o, input logic [63:0] a, input logic [11:0] b,
                        input logic [2:0] id);
    fu.operation = o;
    fu.operand_a = a;
    fu.operand_b = {52'h0, b};
    fu.trans_id  = id;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_s = 1'b0;
    flush = 1'b0; valid = 1'b0; commit = 1'b0;
    flush_s = 1'b0; valid_s = 1'b0; commit_s = 1'b0;
    set_op(CSR_READ, 64'd55, 12'h001, 3'd7);
    tick();
    total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", ready); end
    total++; if (pending !== 1'b0) begin bad++; $display("[TB] FAIL reset_pending got=%b want=0", pending); end
    total++; if (count !== 2'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
    total++; if ({addr, wdata, tid, op} !== {12'h0, 64'h0, 3'd0, ADD})
      begin bad++; $display("[TB] FAIL reset_head got=%h/%h/%h/%0d want=0/0/0/ADD", addr, wdata, tid, op); end
    total++; if (result !== 64'd55) begin bad++; $display("[TB] FAIL reset_result got=%0d want=55", result); end
    total++; if ({ready_s, count_s} !== {1'b1, 3'd0})
      begin bad++; $display("[TB] FAIL reset_ser got=%b/%0d want=1/0", ready_s, count_s); end
    rst_n = 1'b1; rst_s = 1'b1;
  endtask

  task automatic test_single_push();
    set_op(CSR_WRITE, 64'd10, 12'h300, 3'd3);
    valid = 1'b1;
    #1;
    total++; if (result !== 64'd10) begin bad++; $display("[TB] FAIL push_result got=%0d want=10", result); end
    total++; if (pending !== 1'b0) begin bad++; $display("[TB] FAIL push_not_yet got=%b want=0", pending); end
    tick();
    valid = 1'b0;
    total++; if ({addr, wdata, tid, op} !== {12'h300, 64'd10, 3'd3, CSR_WRITE})
      begin bad++; $display("[TB] FAIL push_head got=%h/%0d/%0d/%0d want=300/10/3/CSR_WRITE", addr, wdata, tid, op); end
    total++; if ({count, pending, ready} !== {2'd1, 1'b1, 1'b1})
      begin bad++; $display("[TB] FAIL push_status got=%0d/%b/%b want=1/1/1", count, pending, ready); end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    total++; if ({count, pending} !== {2'd0, 1'b0})
      begin bad++; $display("[TB] FAIL commit_status got=%0d/%b want=0/0", count, pending); end
    total++; if ({addr, wdata, tid, op} !== {12'h0, 64'h0, 3'd0, ADD})
      begin bad++; $display("[TB] FAIL commit_head got=%h/%h/%h/%0d want=0/0/0/ADD", addr, wdata, tid, op); end
  endtask

  task automatic test_full();
    set_op(CSR_SET, 64'h11, 12'h305, 3'd1); valid = 1'b1;
    tick();
    set_op(CSR_CLEAR, 64'h22, 12'h341, 3'd2);
    tick();
    total++; if ({ready, count} !== {1'b0, 2'd2})
      begin bad++; $display("[TB] FAIL full_status got=%b/%0d want=0/2", ready, count); end
    total++; if ({addr, wdata, tid, op} !== {12'h305, 64'h11, 3'd1, CSR_SET})
      begin bad++; $display("[TB] FAIL full_head got=%h/%h/%0d/%0d want=305/11/1/CSR_SET", addr, wdata, tid, op); end
    set_op(CSR_READ, 64'h33, 12'h342, 3'd4);
    tick();
    total++; if ({count, addr} !== {2'd2, 12'h305})
      begin bad++; $display("[TB] FAIL full_drop got=%0d/%h want=2/305", count, addr); end
    valid = 1'b0; commit = 1'b1;
    tick();
    commit = 1'b0;
    total++; if ({addr, wdata, tid, op} !== {12'h341, 64'h22, 3'd2, CSR_CLEAR})
      begin bad++; $display("[TB] FAIL full_pop_head got=%h/%h/%0d/%0d want=341/22/2/CSR_CLEAR", addr, wdata, tid, op); end
    total++; if ({ready, count} !== {1'b1, 2'd1})
      begin bad++; $display("[TB] FAIL full_pop_status got=%b/%0d want=1/1", ready, count); end
  endtask

  task automatic test_full_commit_and_push();
    set_op(CSR_WRITE, 64'h44, 12'h343, 3'd5); valid = 1'b1;
    tick();
    total++; if (count !== 2'd2) begin bad++; $display("[TB] FAIL refill_count got=%0d want=2", count); end
    set_op(CSR_SET, 64'h55, 12'h344, 3'd6); commit = 1'b1;
    tick();
    total++; if ({count, addr, wdata} !== {2'd1, 12'h343, 64'h44})
      begin bad++; $display("[TB] FAIL full_both got=%0d/%h/%h want=1/343/44", count, addr, wdata); end
    valid = 1'b0; commit = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [2:0]  exp_tid;
    for (int i = 0; i < 5; i++) begin
      exp_addr  = 12'h350 + 12'(i);
      exp_wdata = 64'h100 + 64'(i);
      exp_tid   = 3'(i);
      set_op(CSR_SET, exp_wdata, exp_addr, exp_tid);
      valid = 1'b1; commit = 1'b1;
      tick();
      total++; if ({count, addr, wdata, tid, op} !== {2'd1, exp_addr, exp_wdata, exp_tid, CSR_SET})
        begin bad++; $display("[TB] FAIL b2b_%0d got=%0d/%h/%h/%0d want=1/%h/%h/%0d", i, count, addr, wdata, tid, exp_addr, exp_wdata, exp_tid); end
    end
    valid = 1'b0; commit = 1'b0;
  endtask

  task automatic test_flush();
    set_op(CSR_WRITE, 64'h60, 12'h360, 3'd2); valid = 1'b1;
    tick();
    total++; if (count !== 2'd2) begin bad++; $display("[TB] FAIL preflush_count got=%0d want=2", count); end
    set_op(CSR_WRITE, 64'h61, 12'h361, 3'd3); flush = 1'b1; commit = 1'b1;
    tick();
    flush = 1'b0; commit = 1'b0; valid = 1'b0;
    total++; if ({count, ready, pending} !== {2'd0, 1'b1, 1'b0})
      begin bad++; $display("[TB] FAIL flush_status got=%0d/%b/%b want=0/1/0", count, ready, pending); end
    total++; if ({addr, wdata, tid, op} !== {12'h0, 64'h0, 3'd0, ADD})
      begin bad++; $display("[TB] FAIL flush_head got=%h/%h/%h/%0d want=0/0/0/ADD", addr, wdata, tid, op); end
    set_op(CSR_CLEAR, 64'h70, 12'h370, 3'd7); valid = 1'b1;
    tick();
    valid = 1'b0;
    total++; if ({count, addr, wdata, tid} !== {2'd1, 12'h370, 64'h70, 3'd7})
      begin bad++; $display("[TB] FAIL postflush_push got=%0d/%h/%h/%0d want=1/370/70/7", count, addr, wdata, tid); end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    total++; if (count !== 2'd0) begin bad++; $display("[TB] FAIL postflush_pop got=%0d want=0", count); end
  endtask

  task automatic test_commit_empty();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    total++; if ({count, ready, pending} !== {2'd0, 1'b1, 1'b0})
      begin bad++; $display("[TB] FAIL empty_commit got=%0d/%b/%b want=0/1/0", count, ready, pending); end
    set_op(CSR_READ, 64'h80, 12'h380, 3'd1); valid = 1'b1;
    tick();
    valid = 1'b0;
    total++; if ({count, addr, wdata, op} !== {2'd1, 12'h380, 64'h80, CSR_READ})
      begin bad++; $display("[TB] FAIL empty_commit_push got=%0d/%h/%h/%0d want=1/380/80/CSR_READ", count, addr, wdata, op); end
  endtask

  task automatic test_serialize();
    set_op(CSR_WRITE, 64'h90, 12'h390, 3'd4); valid_s = 1'b1;
    tick();
    total++; if ({ready_s, count_s} !== {1'b0, 3'd1})
      begin bad++; $display("[TB] FAIL ser_push got=%b/%0d want=0/1", ready_s, count_s); end
    set_op(CSR_SET, 64'h91, 12'h391, 3'd5);
    tick();
    valid_s = 1'b0;
    total++; if ({count_s, addr_s, wdata_s} !== {3'd1, 12'h390, 64'h90})
      begin bad++; $display("[TB] FAIL ser_drop got=%0d/%h/%h want=1/390/90", count_s, addr_s, wdata_s); end
    commit_s = 1'b1;
    tick();
    total++; if ({ready_s, count_s} !== {1'b1, 3'd0})
      begin bad++; $display("[TB] FAIL ser_commit got=%b/%0d want=1/0", ready_s, count_s); end
    tick();
    commit_s = 1'b0;
    total++; if ({ready_s, count_s, pending_s} !== {1'b1, 3'd0, 1'b0})
      begin bad++; $display("[TB] FAIL ser_empty_commit got=%b/%0d/%b want=1/0/0", ready_s, count_s, pending_s); end
  endtask

  task automatic test_async_reset();
    set_op(CSR_CLEAR, 64'hA0, 12'h3A0, 3'd6); valid_s = 1'b1;
    tick();
    valid_s = 1'b0;
    total++; if ({count_s, pending_s} !== {3'd1, 1'b1})
      begin bad++; $display("[TB] FAIL prereset got=%0d/%b want=1/1", count_s, pending_s); end
    #2;
    rst_s = 1'b0;
    #1;
    total++; if ({count_s, ready_s, pending_s} !== {3'd0, 1'b1, 1'b0})
      begin bad++; $display("[TB] FAIL async_reset got=%0d/%b/%b want=0/1/0", count_s, ready_s, pending_s); end
    total++; if ({addr_s, wdata_s, tid_s, op_s} !== {12'h0, 64'h0, 3'd0, ADD})
      begin bad++; $display("[TB] FAIL async_reset_head got=%h/%h/%h/%0d want=0/0/0/ADD", addr_s, wdata_s, tid_s, op_s); end
    total++; if (result_s !== 64'hA0) begin bad++; $display("[TB] FAIL async_reset_result got=%h want=a0", result_s); end
    tick();
    rst_s = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_push();
    test_full();
    test_full_commit_and_push();
    test_back_to_back();
    test_flush();
    test_commit_empty();
    test_serialize();
    test_async_reset();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
